// File: rtl/bitonic_merge_pipe.sv
// bitonic_merge_pipe
//   Pipelined bitonic merger. A bitonic vector of N elements (W bits each) is
//   sorted into ascending or descending order by S = log2(N) registered
//   compare-exchange stages. Each vector carries its own direction bit, so
//   consecutive vectors may be sorted in different orders.
//
//   Optional feature macro: BITONIC_SIGNED_COMPARE_EN
//     defined   -> elements compared as two's-complement signed values
//     undefined -> elements compared as unsigned values
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   direction  1 = ascending (element 0 smallest), 0 = descending
//   in_valid   IN/direction hold a vector
//   in_ready   block accepts the vector this cycle
//   IN         bitonic input, element i at bits [W*i+W-1 : W*i]
//   out_valid  OUT holds a merged vector
//   out_ready  downstream accepts OUT
//   OUT        merged vector, same packing as IN
//   busy       at least one stage holds a valid vector

module bitonic_merge_pipe #(
  parameter int W = 16,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         direction,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N*W-1:0] IN,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N*W-1:0] OUT,
  output logic         busy
);

  localparam int S = $clog2(N);

  // Stage registers. The direction copy is kept for every stage that feeds a
  // later compare; the final stage has no further compare, so a direction bit
  // there would be dead logic.
  logic [N*W-1:0] data_q [S];
  logic [N*W-1:0] data_d [S];
  logic [S-1:0]   valid_q, valid_d;
  logic [S-2:0]   dir_q, dir_d;
  logic           advance;

  // Element ordering used by every compare-exchange.
  function automatic logic greater(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef BITONIC_SIGNED_COMPARE_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // One half-cleaner layer: pairs (i, i+d) with bit d of i clear. A swap only
  // happens on strict inequality, so equal elements never move.
  function automatic logic [N*W-1:0] cx_stage(input logic [N*W-1:0] v,
                                              input int d,
                                              input logic asc);
    logic [N*W-1:0] r;
    logic [W-1:0]   lo;
    logic [W-1:0]   hi;
    r = v;
    for (int i = 0; i < N; i++) begin
      if ((i & d) == 0) begin
        lo = v[W*i +: W];
        hi = v[W*(i+d) +: W];
        if (asc ? greater(lo, hi) : greater(hi, lo)) begin
          r[W*i +: W]     = hi;
          r[W*(i+d) +: W] = lo;
        end
      end
    end
    return r;
  endfunction

  // Global enable: the whole pipe moves together unless the final stage holds
  // a vector the downstream is not taking. Bubbles enter stage 0 whenever the
  // pipe advances without an input.
  always_comb begin
    advance = !valid_q[S-1] || out_ready;
    for (int s = 0; s < S; s++) begin
      data_d[s] = data_q[s];
    end
    valid_d = valid_q;
    dir_d   = dir_q;
    if (advance) begin
      data_d[0]  = cx_stage(IN, N >> 1, direction);
      valid_d[0] = in_valid;
      dir_d[0]   = direction;
      for (int s = 1; s < S; s++) begin
        data_d[s]  = cx_stage(data_q[s-1], N >> (s + 1), dir_q[s-1]);
        valid_d[s] = valid_q[s-1];
        if (s < S - 1) begin
          dir_d[s] = dir_q[s-1];
        end
      end
    end
  end

  // Reset clears data as well as valid so OUT reads zero after reset and any
  // in-flight or same-cycle vector is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < S; s++) begin
        data_q[s] <= '0;
      end
      valid_q <= '0;
      dir_q   <= '0;
    end else begin
      for (int s = 0; s < S; s++) begin
        data_q[s] <= data_d[s];
      end
      valid_q <= valid_d;
      dir_q   <= dir_d;
    end
  end

  assign in_ready  = advance;
  assign out_valid = valid_q[S-1];
  assign OUT       = data_q[S-1];
  assign busy      = |valid_q;

endmodule

// File: tb/tb_bitonic_merge_pipe.sv
// Bench for bitonic_merge_pipe: an N=4 instance driven with directed vectors
// and hand-written handshake/reset sequences, and an N=16 instance driven
// with random bitonic vectors under random backpressure.

module tb_bitonic_merge_pipe;

  logic         clk = 1'b0;
  logic         rst;

  logic         dir4, in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [63:0]  in4, out4;

  logic         dir16, in_valid16, in_ready16, out_valid16, out_ready16, busy16;
  logic [255:0] in16, out16;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [63:0] vin;
    logic        dir;
    logic [63:0] vexp;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  bitonic_merge_pipe #(.W(16), .N(4)) dut4 (
    .clk(clk), .rst(rst), .direction(dir4), .in_valid(in_valid4),
    .in_ready(in_ready4), .IN(in4), .out_valid(out_valid4),
    .out_ready(out_ready4), .OUT(out4), .busy(busy4)
  );

  bitonic_merge_pipe #(.W(16), .N(16)) dut16 (
    .clk(clk), .rst(rst), .direction(dir16), .in_valid(in_valid16),
    .in_ready(in_ready16), .IN(in16), .out_valid(out_valid16),
    .out_ready(out_ready16), .OUT(out16), .busy(busy16)
  );

  function automatic logic [63:0] pack4(input logic [15:0] e0, input logic [15:0] e1,
                                        input logic [15:0] e2, input logic [15:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  function automatic logic tb_greater(input logic [15:0] a, input logic [15:0] b);
`ifdef BITONIC_SIGNED_COMPARE_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // Reference: plain bubble sort of 16 elements.
  function automatic logic [255:0] ref_sort16(input logic [255:0] v, input logic asc);
    logic [15:0] e [16];
    logic [15:0] t;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) e[i] = v[16*i +: 16];
    for (int i = 0; i < 15; i++) begin
      for (int j = 0; j < 15 - i; j++) begin
        if (asc ? tb_greater(e[j], e[j+1]) : tb_greater(e[j+1], e[j])) begin
          t = e[j]; e[j] = e[j+1]; e[j+1] = t;
        end
      end
    end
    for (int i = 0; i < 16; i++) r[16*i +: 16] = e[i];
    return r;
  endfunction

  // Random bitonic vector: sorted values dealt into a rising then falling
  // half, then cyclically rotated.
  task automatic make_bitonic(output logic [255:0] v);
    logic [255:0] r;
    logic [255:0] s;
    logic [15:0]  e [16];
    int           rot;
    for (int i = 0; i < 16; i++) begin
      r[16*i +: 16] = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 65535))
                                                  : 16'($urandom_range(0, 7));
    end
    s = ref_sort16(r, 1'b1);
    for (int k = 0; k < 8; k++) begin
      e[k]      = s[16*(2*k) +: 16];
      e[15 - k] = s[16*(2*k+1) +: 16];
    end
    rot = $urandom_range(0, 15);
    for (int i = 0; i < 16; i++) v[16*i +: 16] = e[(i + rot) % 16];
  endtask

  task automatic next_cycle;
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [63:0] v, input logic d, input logic vld);
    in4       = v;
    dir4      = d;
    in_valid4 = vld;
  endtask

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  initial begin
    logic [63:0]  va, vb, vc;
    logic [255:0] exp_q [$];
    logic [255:0] cur;
    logic         cur_dir;
    logic         need_new;
    int           seen;
    int           sent;
    int           rcvd;

    va = pack4(16'd1, 16'd5, 16'd7, 16'd3);
    vb = pack4(16'd2, 16'd9, 16'd6, 16'd1);
    vc = pack4(16'd8, 16'd8, 16'd8, 16'd8);

    vecs[0] = '{vin: va, dir: 1'b1, vexp: pack4(16'd1, 16'd3, 16'd5, 16'd7)};
    vecs[1] = '{vin: va, dir: 1'b0, vexp: pack4(16'd7, 16'd5, 16'd3, 16'd1)};
    vecs[2] = '{vin: vb, dir: 1'b0, vexp: pack4(16'd9, 16'd6, 16'd2, 16'd1)};
    vecs[3] = '{vin: pack4(16'd4, 16'd4, 16'd4, 16'd4), dir: 1'b1,
                vexp: pack4(16'd4, 16'd4, 16'd4, 16'd4)};
    vecs[5] = '{vin: pack4(16'd3, 16'd1, 16'd2, 16'd0), dir: 1'b1,
                vexp: pack4(16'd0, 16'd2, 16'd1, 16'd3)};
`ifdef BITONIC_SIGNED_COMPARE_EN
    vecs[4] = '{vin: pack4(16'hFFFF, 16'h0001, 16'h0002, 16'h8000), dir: 1'b1,
                vexp: pack4(16'h8000, 16'hFFFF, 16'h0001, 16'h0002)};
    vecs[6] = '{vin: pack4(16'h0000, 16'h0000, 16'hFFFF, 16'h0000), dir: 1'b1,
                vexp: pack4(16'hFFFF, 16'h0000, 16'h0000, 16'h0000)};
`else
    vecs[4] = '{vin: pack4(16'hFFFF, 16'h0001, 16'h0002, 16'h8000), dir: 1'b1,
                vexp: pack4(16'h0001, 16'h0002, 16'h8000, 16'hFFFF)};
    vecs[6] = '{vin: pack4(16'h0000, 16'h0000, 16'hFFFF, 16'h0000), dir: 1'b1,
                vexp: pack4(16'h0000, 16'h0000, 16'h0000, 16'hFFFF)};
`endif

    // Reset, with a vector presented during reset that must be dropped.
    rst = 1'b1;
    out_ready4 = 1'b1;
    out_ready16 = 1'b1;
    in_valid16 = 1'b0;
    in16 = '0;
    dir16 = 1'b1;
    applyStimulus(va, 1'b1, 1'b1);
    next_cycle;
    checkOutput("in_ready_during_reset", 256'(in_ready4), 256'(1));
    next_cycle;
    checkOutput("reset_out_valid", 256'(out_valid4), 256'(0));
    checkOutput("reset_busy", 256'(busy4), 256'(0));
    checkOutput("reset_out", 256'(out4), 256'(0));
    checkOutput("reset_in_ready", 256'(in_ready4), 256'(1));
    rst = 1'b0;
    applyStimulus(va, 1'b1, 1'b0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      next_cycle;
      if (out_valid4 || busy4) seen++;
    end
    checkOutput("reset_transfer_dropped", 256'(seen), 256'(0));

    // Back-to-back vectors with opposite directions; latency of 2 cycles.
    applyStimulus(va, 1'b1, 1'b1);
    next_cycle;
    applyStimulus(va, 1'b0, 1'b1);
    checkOutput("latency_not_early", 256'(out_valid4), 256'(0));
    checkOutput("busy_in_flight", 256'(busy4), 256'(1));
    next_cycle;
    applyStimulus(va, 1'b1, 1'b0);
    checkOutput("b2b_first_valid", 256'(out_valid4), 256'(1));
    checkOutput("b2b_first_data", 256'(out4), 256'(pack4(16'd1, 16'd3, 16'd5, 16'd7)));
    next_cycle;
    checkOutput("b2b_second_valid", 256'(out_valid4), 256'(1));
    checkOutput("b2b_second_data", 256'(out4), 256'(pack4(16'd7, 16'd5, 16'd3, 16'd1)));
    next_cycle;
    checkOutput("b2b_drained_valid", 256'(out_valid4), 256'(0));
    checkOutput("b2b_drained_busy", 256'(busy4), 256'(0));

    // Directed table, one vector at a time.
    for (int k = 0; k < 7; k++) begin
      applyStimulus(vecs[k].vin, vecs[k].dir, 1'b1);
      next_cycle;
      applyStimulus(vecs[k].vin, vecs[k].dir, 1'b0);
      next_cycle;
      checkOutput($sformatf("vec%0d_valid", k), 256'(out_valid4), 256'(1));
      checkOutput($sformatf("vec%0d_data", k), 256'(out4), 256'(vecs[k].vexp));
      next_cycle;
    end

    // Backpressure: downstream stalls for 3 cycles while A is presented.
    applyStimulus(va, 1'b1, 1'b1);
    next_cycle;
    applyStimulus(vb, 1'b0, 1'b1);
    next_cycle;
    applyStimulus(vb, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      out_ready4 = 1'b0;
      #1;
      checkOutput($sformatf("stall%0d_valid", i), 256'(out_valid4), 256'(1));
      checkOutput($sformatf("stall%0d_data", i), 256'(out4), 256'(pack4(16'd1, 16'd3, 16'd5, 16'd7)));
      checkOutput($sformatf("stall%0d_in_ready", i), 256'(in_ready4), 256'(0));
      next_cycle;
    end
    out_ready4 = 1'b1;
    #1;
    checkOutput("stall_release_data", 256'(out4), 256'(pack4(16'd1, 16'd3, 16'd5, 16'd7)));
    checkOutput("stall_release_in_ready", 256'(in_ready4), 256'(1));
    next_cycle;
    checkOutput("stall_second_valid", 256'(out_valid4), 256'(1));
    checkOutput("stall_second_data", 256'(out4), 256'(pack4(16'd9, 16'd6, 16'd2, 16'd1)));
    next_cycle;
    checkOutput("stall_no_duplicate", 256'(out_valid4), 256'(0));

    // Reset with two vectors in flight and a third presented alongside reset.
    applyStimulus(va, 1'b1, 1'b1);
    next_cycle;
    applyStimulus(vb, 1'b0, 1'b1);
    next_cycle;
    rst = 1'b1;
    applyStimulus(vc, 1'b1, 1'b1);
    #1;
    checkOutput("midreset_busy_before", 256'(busy4), 256'(1));
    checkOutput("midreset_in_ready", 256'(in_ready4), 256'(1));
    next_cycle;
    rst = 1'b0;
    applyStimulus(vc, 1'b1, 1'b0);
    checkOutput("midreset_out_valid", 256'(out_valid4), 256'(0));
    checkOutput("midreset_busy", 256'(busy4), 256'(0));
    checkOutput("midreset_out", 256'(out4), 256'(0));
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      next_cycle;
      if (out_valid4) seen++;
    end
    checkOutput("midreset_no_stale", 256'(seen), 256'(0));

    // N=16: random bitonic vectors with random valid/ready.
    sent = 0;
    rcvd = 0;
    need_new = 1'b1;
    cur = '0;
    cur_dir = 1'b1;
    for (int cyc = 0; cyc < 20000 && rcvd < 1000; cyc++) begin
      out_ready16 = ($urandom_range(0, 3) != 0);
      if (sent < 1000) begin
        if (need_new) begin
          make_bitonic(cur);
          cur_dir = 1'($urandom_range(0, 1));
          need_new = 1'b0;
        end
        in16 = cur;
        dir16 = cur_dir;
        in_valid16 = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid16 = 1'b0;
      end
      #1;
      if (in_valid16 && in_ready16) begin
        exp_q.push_back(ref_sort16(cur, cur_dir));
        sent++;
        need_new = 1'b1;
      end
      if (out_valid16 && out_ready16) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL rand_unexpected_output: got %0h, required no output", out16);
        end else begin
          checkOutput("rand_out", out16, exp_q.pop_front());
        end
        rcvd++;
      end
      next_cycle;
    end
    in_valid16 = 1'b0;
    checkOutput("rand_count", 256'(rcvd), 256'(1000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bitonic_merge_pipe.md
BITONIC_MERGE_PIPE -- requirements
Module: bitonic_merge_pipe

Interface
REQ-001 The block SHALL have parameter W, default 16, meaning element width in bits (>= 2).
REQ-002 The block SHALL have parameter N, default 8, meaning elements per vector (power of two, 4..32).
REQ-003 The block SHALL have local parameter S = log2(N), meaning the number of compare-exchange stages.
REQ-004 The block SHALL have port clk  input  1  meaning the single clock; all state is updated on its rising edge.
REQ-005 The block SHALL have port rst  input  1  meaning reset, synchronous and active-high.
REQ-006 The block SHALL have port direction  input  1  meaning sort order per vector: 1 = ascending (element 0 smallest), 0 = descending.
REQ-007 The block SHALL have port in_valid  input  1  meaning IN and direction hold a vector.
REQ-008 The block SHALL have port in_ready  output  1  meaning the block accepts the vector this cycle.
REQ-009 The block SHALL have port IN  input  N*W  meaning a bitonic input vector, with element i at bits [W*i+W-1 : W*i].
REQ-010 The block SHALL have port out_valid  output  1  meaning OUT holds a merged vector.
REQ-011 The block SHALL have port out_ready  input  1  meaning the downstream accepts OUT.
REQ-012 The block SHALL have port OUT  output  N*W  meaning the merged vector, using the same element packing as IN.
REQ-013 The block SHALL have port busy  output  1  meaning at least one stage holds a valid vector.

Function
REQ-014 The block SHALL be an S-stage pipeline; stage s (0..S-1) uses distance d = N >> (s+1) and compare-exchanges each pair (i, i+d) with (i & d) == 0.
REQ-015 For direction=1, each compare-exchange SHALL place the minimum at the lower index; for direction=0, it SHALL place the maximum there.
REQ-016 Equal elements SHALL NOT be swapped.
REQ-017 Each stage SHALL register its data, its valid bit, and a copy of direction, so each vector keeps its own direction through the pipeline.
REQ-018 The pipeline SHALL use a global enable: advance = !out_valid || out_ready; when advance = 0, every stage holds.
REQ-019 in_ready SHALL equal advance, combinationally; a transfer occurs when in_valid && in_ready.
REQ-020 When advance = 1 and in_valid = 0, a bubble (valid = 0) SHALL enter stage 0.
REQ-021 With out_ready held at 1, latency SHALL be exactly S cycles from input transfer to out_valid, with throughput of one vector per cycle.
REQ-022 OUT and out_valid SHALL be driven from the final stage registers, with no combinational path from IN to OUT.
REQ-023 While out_valid = 1 and out_ready = 0, OUT SHALL remain stable and in_ready SHALL be 0.
REQ-024 If the input is not bitonic, the output SHALL be the deterministic network result; no sortedness is guaranteed and no error is flagged.
REQ-025 busy SHALL be the OR of all stage valid bits.

Reset
REQ-026 When rst = 1 at a clock edge, all stage valid bits SHALL clear, and OUT, out_valid and busy SHALL be 0 from the next cycle.
REQ-027 In-flight vectors SHALL be discarded on reset mid-operation, with no partial output.
REQ-028 in_ready SHALL be 1 during and after reset, because out_valid = 0.
REQ-029 A transfer presented in the same cycle as rst = 1 SHALL be dropped.

Configuration
REQ-030 With macro BITONIC_SIGNED_COMPARE_EN defined, elements SHALL be compared as two's-complement signed values.
REQ-031 With BITONIC_SIGNED_COMPARE_EN not defined, elements SHALL be compared as unsigned values.
REQ-032 BITONIC_SIGNED_COMPARE_EN SHALL NOT affect latency, handshake, or element packing.

Verification (N=4, W=16 unless noted; S=2)
REQ-033 The bench SHALL check: IN elements {1,5,7,3} (element 0 first), direction=1, out_ready=1 -> OUT {1,3,5,7}, out_valid high exactly 2 cycles after the transfer.
REQ-034 The bench SHALL check: the same IN with direction=0, sent on the cycle after the vector above -> consecutive outputs {1,3,5,7} then {7,5,3,1}, each keeping its own direction.
REQ-035 The bench SHALL check: out_ready=0 for 3 cycles while out_valid=1 -> OUT held stable, in_ready=0, no vector lost or duplicated after out_ready returns to 1.
REQ-036 The bench SHALL check: 2 vectors in flight, rst=1 for one cycle -> out_valid=0, busy=0, OUT=0 next cycle, and no stale output afterwards.
REQ-037 The bench SHALL check: IN {0xFFFF,0x0001,0x0002,0x8000}, direction=1 -> {0x0001,0x0002,0x8000,0xFFFF} without the macro, and {0x8000,0xFFFF,0x0001,0x0002} with BITONIC_SIGNED_COMPARE_EN.
REQ-038 The bench SHALL check: N=16 with 1000 random bitonic vectors and random out_ready -> every output matches a reference sort and arrival order is preserved.
